// File: rtl/laser_fire_ctrl.sv
// Shot scheduler: turns fire keypresses into laser shots in a fixed slot pool, one update per frame.
// Optional build macro AUTO_FIRE_EN: a held FIRE_KEY re-fires every COOLDOWN frames.
module laser_fire_ctrl #(
    parameter int          NUM_SHOTS = 4,
    parameter int          COOLDOWN  = 8,
    parameter int          SHOT_STEP = 6,
    parameter logic [7:0]  FIRE_KEY  = 8'h1A,
    parameter logic [7:0]  START_KEY = 8'h2C
) (
    input  logic                      frame_clk,
    input  logic                      Reset,
    input  logic [7:0]                keycode,
    input  logic [9:0]                ShipX,
    input  logic [9:0]                ShipY,
    input  logic [9:0]                ShipSX,
    input  logic [NUM_SHOTS-1:0]      hit,
    output logic [NUM_SHOTS-1:0]      ShotActive,
    output logic [10*NUM_SHOTS-1:0]   ShotX,
    output logic [10*NUM_SHOTS-1:0]   ShotY,
    output logic                      fire_pulse,
    output logic [7:0]                shot_count,
    output logic                      fsm_state
);

    typedef enum logic {READY = 1'b0, COOL = 1'b1} state_t;

    localparam logic [7:0] CD_LOAD = 8'(COOLDOWN - 1);
    localparam logic [9:0] STEP    = 10'(SHOT_STEP);

    state_t               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [7:0]           prev_key;
    logic [9:0]           x_q [NUM_SHOTS];
    logic [9:0]           y_q [NUM_SHOTS];
    logic                 press, accept, start, free_found;
    logic [NUM_SHOTS-1:0] alloc_oh;
    logic [9:0]           spawn_x;

    assign start = (keycode == START_KEY);
`ifdef AUTO_FIRE_EN
    assign press = (keycode == FIRE_KEY);
`else
    assign press = (keycode == FIRE_KEY) && (prev_key != FIRE_KEY);
`endif
    assign spawn_x   = ShipX + (ShipSX >> 1);
    assign fsm_state = state_q;

    // Lowest-index free slot, judged on pre-edge activity so a slot freed this frame waits one frame.
    always_comb begin
        alloc_oh   = '0;
        free_found = 1'b0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            if (!ShotActive[i] && !free_found) begin
                alloc_oh[i] = 1'b1;
                free_found  = 1'b1;
            end
        end
    end

    assign accept = !start && press && (state_q == READY) && free_found;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = READY;
            cnt_d   = '0;
        end else begin
            case (state_q)
                READY: begin
                    if (accept && (CD_LOAD != 8'd0)) begin
                        state_d = COOL;
                        cnt_d   = CD_LOAD;
                    end
                end
                COOL: begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = READY;
                end
                default: begin
                    state_d = READY;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Spawned shots do not move in their spawn frame; hit beats the top-edge retire.
    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            ShotActive <= '0;
            fire_pulse <= 1'b0;
            shot_count <= '0;
            prev_key   <= '0;
            for (int i = 0; i < NUM_SHOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else begin
            prev_key   <= keycode;
            fire_pulse <= accept;
            if (accept) shot_count <= shot_count + 8'd1;
            for (int i = 0; i < NUM_SHOTS; i++) begin
                if (start) begin
                    ShotActive[i] <= 1'b0;
                end else if (accept && alloc_oh[i]) begin
                    ShotActive[i] <= 1'b1;
                    x_q[i]        <= spawn_x;
                    y_q[i]        <= ShipY;
                end else if (ShotActive[i]) begin
                    if (hit[i]) begin
                        ShotActive[i] <= 1'b0;
                    end else if (y_q[i] < STEP) begin
                        ShotActive[i] <= 1'b0;
                    end else begin
                        y_q[i] <= y_q[i] - STEP;
                    end
                end
            end
        end
    end

    always_comb begin
        ShotX = '0;
        ShotY = '0;
        for (int i = 0; i < NUM_SHOTS; i++) begin
            ShotX[10*i +: 10] = x_q[i];
            ShotY[10*i +: 10] = y_q[i];
        end
    end

endmodule
